seg7_mux_display: RTL and testbench
===================================

SEG7_MUX_DISPLAY -- requirements
Module: seg7_mux_display

Interface
REQ-001 Parameters SHALL be: DIGITS, default 4, number of multiplexed digits (1..8); VALUE_W, default 8, width of the binary input (4..32); REFRESH_DIV, default 20000, clk cycles per digit slot (>=2).
REQ-002 One clock; reset is synchronous and active-high; ports named clk and reset.
REQ-003 Ports SHALL be: clk in 1 system clock; reset in 1 synchronous active-high reset; value in VALUE_W number to display; value_valid in 1 load strobe; mode in 1 (0 hex, 1 decimal), sampled with value_valid; blank_lz in 1 leading-zero suppression, sampled with value_valid; seg7 out 7 segments {g,f,e,d,c,b,a}, active-low; select out DIGITS digit enables, active-low, one-hot; busy out 1 decimal conversion in progress; overflow out 1 value does not fit in DIGITS.

Function
REQ-004 A prescaler SHALL count 0..REFRESH_DIV-1; on wrap, digit index SHALL advance by one and wrap from DIGITS-1 to 0.
REQ-005 select SHALL drive low only the bit of the current digit index; seg7 SHALL be the registered pattern of that digit, updated in the same cycle as select.
REQ-006 Control FSM SHALL have states IDLE and CONVERT; value_valid is accepted only in IDLE and SHALL be ignored while busy=1.
REQ-007 Hex mode: digit i = value[4i+3:4i]; the display registers and overflow SHALL update on the clock edge following the accepted strobe; busy stays 0.
REQ-008 Hex mode: overflow SHALL be 1 iff any value bit at or above 4*DIGITS is set; upper bits are truncated.
REQ-009 Decimal mode: FSM SHALL enter CONVERT, busy SHALL be 1 for exactly VALUE_W cycles (shift-add-3 conversion, one bit per cycle), then return to IDLE with the display registers updated atomically in the cycle busy falls.
REQ-010 Decimal mode: if value >= 10^DIGITS, every digit SHALL show dash (7'b0111111) and overflow SHALL be 1; otherwise overflow 0.
REQ-011 With blank_lz=1, all-zero digits above the most significant non-zero digit SHALL be blank (7'b1111111); digit 0 SHALL always display.
REQ-012 Segment patterns SHALL be standard 0-9, A, b, C, d, E, F (e.g. 0=7'b1000000, 5=7'b0010010, A=7'b0001000).
REQ-013 Display contents SHALL hold unchanged between accepted strobes; scanning SHALL never pause during conversion.

Reset
REQ-014 While reset=1: seg7=all ones, select=all ones, busy=0, overflow=0, prescaler=0, digit index=0, display registers = digit value 0 with no blanking, FSM=IDLE.
REQ-015 Reset during CONVERT SHALL abort the conversion; the partial result SHALL never reach the display registers.
REQ-016 First cycle after reset release: select SHALL drive digit 0 low, showing 0.

Configuration
REQ-017 Macro SEG7_DP_EN: when defined, the module SHALL add input dp_mask[DIGITS-1:0] (sampled with value_valid) and output dp (active-low, dp = ~dp_mask[index], timed with select); when undefined, neither port exists and behaviour is otherwise identical.

Structure
REQ-018 Package seg7_pkg SHALL hold the segment pattern constants (hex digits, SEG_BLANK, SEG_DASH) and the FSM state typedef.
REQ-019 The decimal converter SHALL be the sub-module bin2bcd_seq (start, busy, done, VALUE_W in, 4*DIGITS out plus overflow).

Verification (DIGITS=4, VALUE_W=8, REFRESH_DIV=4 unless noted)
REQ-020 Scan: after reset, select SHALL step 1110, 1101, 1011, 0111, 1110, changing every 4 cycles.
REQ-021 Hex 0xA5, blank_lz=0: digits 0..3 SHALL show 5, A, 0, 0 (7'b0010010, 7'b0001000, 7'b1000000 x2); busy stays 0.
REQ-022 Decimal 255, blank_lz=1: busy SHALL be high for 8 cycles; digits then show 5, 5, 2, blank; overflow 0.
REQ-023 Decimal 0, blank_lz=1: digit 0 shows 7'b1000000; digits 1-3 blank.
REQ-024 VALUE_W=16, decimal 12345: all digits dash, overflow 1; second value_valid (e.g. 0x0001) pulsed mid-busy SHALL be ignored.
REQ-025 Reset asserted during the 4th conversion cycle: busy drops, display shows prior reset state (0), no update after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns, FSM state type and sizing helper for the 7-segment display
package seg7_pkg;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;

    // Packed so that SEG_HEX[n] is the glyph for nibble n
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        SEG_0        // 0
    };

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } seg7_state_e;

    // Decimal digits needed to hold any w-bit unsigned value (log10(2) ~ 0.30103)
    function automatic int bcd_digits(input int w);
        return (w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to BCD converter, one input bit per cycle
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int VALUE_W = 8,
    parameter int DIGITS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [VALUE_W-1:0]    value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BCD_D = bcd_digits(VALUE_W);
    localparam int EXT_D = (BCD_D > DIGITS) ? BCD_D : DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    logic [VALUE_W-1:0]  shift_q;
    logic [4*BCD_D-1:0]  bcd_q;
    logic [4*BCD_D-1:0]  bcd_adj;
    logic [4*BCD_D-1:0]  bcd_step;
    logic [4*EXT_D-1:0]  bcd_ext;
    logic [CNT_W-1:0]    cnt_q;

    // done/bcd/overflow reflect the final step combinationally so the caller
    // can capture the result on the same edge that busy falls
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < BCD_D; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
        bcd_step = (bcd_adj << 1) | (4*BCD_D)'(shift_q[VALUE_W-1]);
        bcd_ext  = (4*EXT_D)'(bcd_step);
    end

    assign done     = busy && (cnt_q == CNT_W'(VALUE_W - 1));
    assign bcd      = bcd_ext[4*DIGITS-1:0];
    assign overflow = |(bcd_ext >> (4*DIGITS));

    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
        end else if (start && !busy) begin
            busy    <= 1'b1;
            cnt_q   <= '0;
            shift_q <= value;
            bcd_q   <= '0;
        end else if (busy) begin
            shift_q <= shift_q << 1;
            bcd_q   <= bcd_step;
            cnt_q   <= cnt_q + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_mux_display.sv
// rtl/seg7_mux_display.sv - multiplexed hex/decimal 7-segment driver; SEG7_DP_EN adds decimal points
module seg7_mux_display
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int VALUE_W     = 8,
    parameter int REFRESH_DIV = 20000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [VALUE_W-1:0]  value,
    input  logic                value_valid,
    input  logic                mode,
    input  logic                blank_lz,
`ifdef SEG7_DP_EN
    input  logic [DIGITS-1:0]   dp_mask,
    output logic                dp,
`endif
    output logic [6:0]          seg7,
    output logic [DIGITS-1:0]   select,
    output logic                busy,
    output logic                overflow
);

    localparam int PSC_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PAD_W = (VALUE_W > 4*DIGITS) ? VALUE_W : 4*DIGITS;

    seg7_state_e          state_q;
    seg7_state_e          state_d;
    logic                 in_convert;
    logic                 accept;
    logic                 conv_start;
    logic                 conv_busy;
    logic                 conv_done;
    logic                 conv_ovf;
    logic [4*DIGITS-1:0]  conv_bcd;
    logic [PAD_W-1:0]     value_ext;
    logic                 hex_ovf;
    logic                 blank_q;
    logic [4*DIGITS-1:0]  src_digits;
    logic                 src_blank;
    logic                 src_dash;
    logic                 lead_zero;
    logic                 load_disp;
    logic                 ovf_d;
    logic [PSC_W-1:0]     psc_q;
    logic [IDX_W-1:0]     idx_q;
    logic [6:0]           disp_q [DIGITS];
    logic [6:0]           disp_d [DIGITS];

    assign in_convert = (state_q == ST_CONVERT);
    assign busy       = in_convert;
    assign accept     = (state_q == ST_IDLE) && value_valid;
    assign conv_start = accept && mode;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (conv_start) state_d = ST_CONVERT;
            ST_CONVERT: if (conv_done || !conv_busy) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    bin2bcd_seq #(
        .VALUE_W (VALUE_W),
        .DIGITS  (DIGITS)
    ) u_bin2bcd (
        .clk      (clk),
        .reset    (reset),
        .start    (conv_start),
        .value    (value),
        .busy     (conv_busy),
        .done     (conv_done),
        .bcd      (conv_bcd),
        .overflow (conv_ovf)
    );

    assign value_ext = PAD_W'(value);
    assign hex_ovf   = |(value_ext >> (4*DIGITS));
    assign load_disp = (accept && !mode) || conv_done;
    assign ovf_d     = in_convert ? conv_ovf : hex_ovf;

    // Hex loads come straight from the input; decimal loads from the converter
    // using the blank_lz captured when the strobe was accepted
    always_comb begin
        src_digits = in_convert ? conv_bcd : value_ext[4*DIGITS-1:0];
        src_blank  = in_convert ? blank_q : blank_lz;
        src_dash   = in_convert && conv_ovf;
        lead_zero  = 1'b1;
        disp_d     = '{default: SEG_BLANK};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (src_digits[4*i +: 4] != 4'd0) begin
                lead_zero = 1'b0;
            end
            if (src_dash) begin
                disp_d[i] = SEG_DASH;
            end else if (src_blank && lead_zero && (i != 0)) begin
                disp_d[i] = SEG_BLANK;
            end else begin
                disp_d[i] = SEG_HEX[src_digits[4*i +: 4]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            psc_q    <= '0;
            idx_q    <= '0;
            seg7     <= SEG_BLANK;
            select   <= '1;
            overflow <= 1'b0;
            blank_q  <= 1'b0;
            disp_q   <= '{default: SEG_0};
        end else begin
            state_q <= state_d;
            if (psc_q == PSC_W'(REFRESH_DIV - 1)) begin
                psc_q <= '0;
                idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                psc_q <= psc_q + 1'b1;
            end
            select <= ~(DIGITS'(1) << idx_q);
            seg7   <= disp_q[idx_q];
            if (accept) begin
                blank_q <= blank_lz;
            end
            if (load_disp) begin
                disp_q   <= disp_d;
                overflow <= ovf_d;
            end
        end
    end

`ifdef SEG7_DP_EN
    logic [DIGITS-1:0] dp_mask_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_mask_q <= '0;
            dp        <= 1'b1;
        end else begin
            if (accept) begin
                dp_mask_q <= dp_mask;
            end
            dp <= ~dp_mask_q[idx_q];
        end
    end
`else
    // Without decimal points the scan path above drives every output.
`endif

endmodule

// File: tb/tb_seg7_mux_display.sv
// tb/tb_seg7_mux_display.sv - randomized self-checking bench for seg7_mux_display
module tb_seg7_mux_display;

    logic        clk;
    logic        reset;
    logic [7:0]  value;
    logic        value_valid;
    logic        mode;
    logic        blank_lz;
    logic [6:0]  seg7;
    logic [3:0]  select;
    logic        busy;
    logic        overflow;

    logic [15:0] value16;
    logic        valid16;
    logic        mode16;
    logic        blank16;
    logic [6:0]  seg7_16;
    logic [3:0]  select16;
    logic        busy16;
    logic        ovf16;

`ifdef SEG7_DP_EN
    logic [3:0]  dp_mask;
    logic        dp;
    logic [3:0]  dp_mask16;
    logic        dp16;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

    seg7_mux_display #(.DIGITS(4), .VALUE_W(8), .REFRESH_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .value_valid (value_valid),
        .mode        (mode),
        .blank_lz    (blank_lz),
`ifdef SEG7_DP_EN
        .dp_mask     (dp_mask),
        .dp          (dp),
`endif
        .seg7        (seg7),
        .select      (select),
        .busy        (busy),
        .overflow    (overflow)
    );

    seg7_mux_display #(.DIGITS(4), .VALUE_W(16), .REFRESH_DIV(4)) dut16 (
        .clk         (clk),
        .reset       (reset),
        .value       (value16),
        .value_valid (valid16),
        .mode        (mode16),
        .blank_lz    (blank16),
`ifdef SEG7_DP_EN
        .dp_mask     (dp_mask16),
        .dp          (dp16),
`endif
        .seg7        (seg7_16),
        .select      (select16),
        .busy        (busy16),
        .overflow    (ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Glyph digit i should show: positional arithmetic on the number itself
    function automatic logic [6:0] exp_seg(input longint unsigned v, input bit dec,
                                           input bit blk, input int i);
        longint unsigned base;
        longint unsigned p;
        longint unsigned q;
        base = dec ? 64'd10 : 64'd16;
        p = 1;
        if (dec && v >= 10000) return 7'h3f;
        if (!dec) v = v % 65536;
        for (int k = 0; k < i; k++) p = p * base;
        q = v / p;
        if (blk && i > 0 && q == 0) return 7'h7f;
        return seg_tab[int'(q % base)];
    endfunction

    function automatic logic exp_ovf(input longint unsigned v, input bit dec);
        return dec ? (v >= 10000) : (v >= 65536);
    endfunction

    task automatic scan_check(input string tag, input int v, input bit dec, input bit blk);
        int         idx;
        logic [3:0] seen;
        logic [3:0] m;
        seen = '0;
        for (int c = 0; c < 16; c++) begin
            idx = -1;
            for (int k = 0; k < 4; k++) begin
                m = ~(4'b0001 << k);
                if (select == m) idx = k;
            end
            check_eq({tag, "_onehot"}, $countones(~select), 1);
            if (idx >= 0) begin
                seen[idx] = 1'b1;
                check_eq($sformatf("%s_digit%0d", tag, idx), seg7, exp_seg(v, dec, blk, idx));
            end
            tick();
        end
        check_eq({tag, "_all_digits_scanned"}, seen, 4'hf);
    endtask

    task automatic load8(input int v, input bit dec, input bit blk);
        int cnt;
        value       = v[7:0];
        mode        = dec;
        blank_lz    = blk;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        value       = 8'($urandom);
        mode        = 1'($urandom);
        blank_lz    = 1'($urandom);
        if (!dec) begin
            check_eq("hex_busy", busy, 1'b0);
            check_eq("hex_ovf", overflow, exp_ovf(v, 1'b0));
        end else begin
            cnt = 0;
            while (busy === 1'b1 && cnt < 64) begin
                cnt++;
                tick();
            end
            check_eq("dec_busy_cycles", cnt, 8);
            check_eq("dec_ovf", overflow, exp_ovf(v, 1'b1));
        end
        tick();
        scan_check(dec ? "dec" : "hex", v, dec, blk);
    endtask

    initial begin
        int         cnt;
        logic [3:0] m;
        int         rv;
        bit         rd;
        bit         rb;

        reset       = 1'b1;
        value       = '0;
        value_valid = 1'b0;
        mode        = 1'b0;
        blank_lz    = 1'b0;
        value16     = '0;
        valid16     = 1'b0;
        mode16      = 1'b0;
        blank16     = 1'b0;
`ifdef SEG7_DP_EN
        dp_mask     = '0;
        dp_mask16   = '0;
`endif
        repeat (3) tick();
        check_eq("rst_seg7", seg7, 7'h7f);
        check_eq("rst_select", select, 4'hf);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ovf", overflow, 1'b0);

        reset = 1'b0;
        for (int k = 0; k < 17; k++) begin
            tick();
            m = ~(4'b0001 << ((k / 4) % 4));
            check_eq("scan_seq", select, m);
            if (k == 0) check_eq("first_digit0", seg7, 7'h40);
        end

        load8(8'hA5, 1'b0, 1'b0);
        load8(255, 1'b1, 1'b1);
        load8(0, 1'b1, 1'b1);
        load8(8'h0C, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            rv = int'($urandom_range(0, 255));
            rd = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            load8(rv, rd, rb);
        end

        // Abort a conversion with reset in its 4th busy cycle
        load8(8'h3C, 1'b0, 1'b0);
        value       = 8'd123;
        mode        = 1'b1;
        blank_lz    = 1'b0;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        repeat (3) tick();
        check_eq("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        tick();
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_seg7", seg7, 7'h7f);
        check_eq("abort_select", select, 4'hf);
        reset = 1'b0;
        tick();
        scan_check("abort", 0, 1'b0, 1'b0);
        check_eq("abort_ovf", overflow, 1'b0);
        check_eq("abort_busy_after", busy, 1'b0);
        scan_check("abort_hold", 0, 1'b0, 1'b0);

        // 16-bit instance: out-of-range decimal, with a strobe during busy
        value16 = 16'd12345;
        mode16  = 1'b1;
        blank16 = 1'b0;
        valid16 = 1'b1;
        tick();
        valid16 = 1'b0;
        cnt = 0;
        while (busy16 === 1'b1 && cnt < 64) begin
            cnt++;
            if (cnt == 5) begin
                value16 = 16'h0001;
                valid16 = 1'b1;
            end else begin
                valid16 = 1'b0;
            end
            tick();
        end
        valid16 = 1'b0;
        check_eq("w16_busy_cycles", cnt, 16);
        check_eq("w16_ovf", ovf16, exp_ovf(12345, 1'b1));
        tick();
        tick();
        check_eq("w16_no_restart", busy16, 1'b0);
        for (int c = 0; c < 16; c += 3) begin
            check_eq("w16_dash", seg7_16, exp_seg(12345, 1'b1, 1'b0, c % 4));
            repeat (3) tick();
        end
        check_eq("w16_ovf_hold", ovf16, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
